// File: rtl/func_select_encoder.sv
// func_select_encoder
// Debounces 16 function-request lines, encodes a stable request into the
// 4-bit select A,B,C,D, and presents it once per press on a valid/ready
// handshake. Multi-hot requests are flagged on err_multi.
module func_select_encoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          PRIORITY      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        ready_in,
  output logic        valid,
  output logic [3:0]  op,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        err_multi,
  output logic [7:0]  accept_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Count value at which the S-th identical sample has just been seen.
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] held_q, held_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [3:0]  op_q, op_d;
  logic        err_q, err_d;
  logic [7:0]  acc_q, acc_d;

  // Index of the highest set bit; for a one-hot value this is its position.
  function automatic logic [3:0] hi_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // True when more than one bit is set (clearing the lowest bit leaves something).
  function automatic logic is_multi(input logic [15:0] v);
    return ((v & (v - 16'd1)) != 16'd0);
  endfunction

  // Next-state logic: debounce, capture, handshake and release tracking.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    op_d    = op_q;
    err_d   = 1'b0;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (req != 16'd0) begin
          held_d  = req;
          cnt_d   = 8'd1;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (req == 16'd0) begin
          state_d = IDLE;
        end else if (req != held_q) begin
          // A different pattern restarts the stability count.
          held_d = req;
          cnt_d  = 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          if (!is_multi(held_q)) begin
            op_d    = hi_index(held_q);
            valid_d = 1'b1;
            state_d = PRESENT;
          end else if (PRIORITY) begin
            op_d    = hi_index(held_q);
            valid_d = 1'b1;
            err_d   = 1'b1;
            state_d = PRESENT;
          end else begin
            // Rejected: flag it, present nothing, wait for release.
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PRESENT: begin
        // req is ignored here; op stays frozen until the consumer takes it.
        if (ready_in) begin
          valid_d = 1'b0;
          acc_d   = acc_q + 8'd1;
          state_d = RELEASE;
        end else begin
          valid_d = 1'b1;
        end
      end
      RELEASE: begin
        valid_d = 1'b0;
        if (req == 16'd0) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= 16'd0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      op_q    <= 4'd0;
      err_q   <= 1'b0;
      acc_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign valid      = valid_q;
  assign op         = op_q;
  assign A          = op_q[3];
  assign B          = op_q[2];
  assign C          = op_q[1];
  assign D          = op_q[0];
  assign err_multi  = err_q;
  assign accept_cnt = acc_q;

endmodule

// File: tb/tb_func_select_encoder.sv
// Testbench for func_select_encoder: table of presses plus hand sequences,
// scoreboard of expected ops popped when valid rises.
module tb_func_select_encoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst, ready_in;
  logic [15:0] req;
  logic        valid, A, B, C, D, err_multi;
  logic [3:0]  op;
  logic [7:0]  accept_cnt;
  logic        valid_0, A_0, B_0, C_0, D_0, err_multi_0;
  logic [3:0]  op_0;
  logic [7:0]  accept_cnt_0;

  always #5 clk = ~clk;

  func_select_encoder #(.STABLE_CYCLES(S), .PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .ready_in(ready_in), .valid(valid), .op(op),
    .A(A), .B(B), .C(C), .D(D), .err_multi(err_multi), .accept_cnt(accept_cnt)
  );

  func_select_encoder #(.STABLE_CYCLES(S), .PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .ready_in(ready_in), .valid(valid_0), .op(op_0),
    .A(A_0), .B(B_0), .C(C_0), .D(D_0), .err_multi(err_multi_0), .accept_cnt(accept_cnt_0)
  );

  typedef struct { logic [3:0] op; logic err; } exp_t;
  typedef struct { logic [15:0] req; logic [3:0] op; logic err; } vec_t;

  exp_t       sb[$];
  vec_t       vecs[8];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_acc;
  logic       valid_prev = 1'b0;
  logic       valid0_prev = 1'b0;
  int         err1_n, err0_n;
  logic       v0_seen;
  logic [3:0] op0_cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (valid && !valid_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("op", 32'(op), 32'(e.op));
        chk("abcd", 32'({A, B, C, D}), 32'(e.op));
        chk("err_at_capture", 32'(err_multi), 32'(e.err));
      end
    end
    if (err_multi) err1_n++;
    if (err_multi_0) err0_n++;
    if (valid_0 && !valid0_prev) begin
      v0_seen = 1'b1;
      op0_cap = op_0;
    end
    valid_prev  = valid;
    valid0_prev = valid_0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_acc = 8'd0;
  endtask

  // Wait (bounded) for valid; returns number of edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic press(input logic [15:0] r, input logic [3:0] eop, input logic eerr);
    int   n;
    logic any;
    logic onehot;
    sb.push_back('{eop, eerr});
    err1_n  = 0;
    err0_n  = 0;
    v0_seen = 1'b0;
    onehot  = ($countones(r) == 1);
    req      = r;
    ready_in = 1'b1;
    wait_valid(n);
    chk("valid_latency", 32'(n), 32'(S));
    tick();
    exp_acc = exp_acc + 8'd1;
    chk("valid_after_accept", 32'(valid), 32'd0);
    chk("accept_cnt", 32'(accept_cnt), 32'(exp_acc));
    any = 1'b0;
    repeat (3) begin
      tick();
      if (valid) any = 1'b1;
    end
    chk("no_repeat_op", 32'(any), 32'd0);
    chk("err_pulse_count", 32'(err1_n), eerr ? 32'd1 : 32'd0);
    chk("p0_err_count", 32'(err0_n), onehot ? 32'd0 : 32'd1);
    chk("p0_valid_seen", 32'(v0_seen), 32'(onehot));
    if (onehot) chk("p0_op", 32'(op0_cap), 32'(eop));
    req = 16'd0;
    tick();
    tick();
  endtask

  initial begin
    int         n;
    logic [15:0] one;
    vecs[0] = '{16'h0100, 4'h8, 1'b0};
    vecs[1] = '{16'h0001, 4'h0, 1'b0};
    vecs[2] = '{16'h8000, 4'hF, 1'b0};
    vecs[3] = '{16'h0020, 4'h5, 1'b0};
    vecs[4] = '{16'h8001, 4'hF, 1'b1};
    vecs[5] = '{16'h0006, 4'h2, 1'b1};
    vecs[6] = '{16'h1000, 4'hC, 1'b0};
    vecs[7] = '{16'h0300, 4'h9, 1'b1};
    one      = 16'h0001;
    req      = 16'd0;
    ready_in = 1'b0;
    exp_acc  = 8'd0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_abcd", 32'({A, B, C, D}), 32'd0);
    chk("rst_acc", 32'(accept_cnt), 32'd0);
    chk("rst_err", 32'(err_multi), 32'd0);

    // Table-driven presses
    for (int i = 0; i < 8; i++) begin
      press(vecs[i].req, vecs[i].op, vecs[i].err);
    end

    // Debounce restart
    sb.push_back('{4'h1, 1'b0});
    ready_in = 1'b1;
    req = 16'h0001;
    tick();
    tick();
    chk("restart_no_valid_early", 32'(valid), 32'd0);
    req = 16'h0002;
    wait_valid(n);
    chk("restart_latency", 32'(n), 32'(S));
    tick();
    exp_acc = exp_acc + 8'd1;
    chk("restart_acc", 32'(accept_cnt), 32'(exp_acc));
    req = 16'd0;
    tick();
    tick();

    // Backpressure with req changing
    sb.push_back('{4'h4, 1'b0});
    ready_in = 1'b0;
    req = 16'h0010;
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'(S));
    for (int i = 0; i < 10; i++) begin
      req = 16'($urandom);
      tick();
      chk("bp_valid_held", 32'(valid), 32'd1);
      chk("bp_op_stable", 32'(op), 32'h4);
    end
    ready_in = 1'b1;
    tick();
    exp_acc = exp_acc + 8'd1;
    chk("bp_valid_drop", 32'(valid), 32'd0);
    chk("bp_acc", 32'(accept_cnt), 32'(exp_acc));
    chk("bp_op_kept", 32'(op), 32'h4);
    tick();
    chk("bp_single_accept", 32'(accept_cnt), 32'(exp_acc));
    req = 16'd0;
    tick();
    tick();

    // Wrap: 256 accepts from reset bring the counter back to zero
    do_reset();
    for (int i = 0; i < 256; i++) begin
      press(one << (i % 16), 4'(i % 16), 1'b0);
    end
    chk("wrap_to_zero", 32'(accept_cnt), 32'd0);

    // Reset while presenting
    sb.push_back('{4'h7, 1'b0});
    ready_in = 1'b0;
    req = 16'h0080;
    wait_valid(n);
    chk("pres_latency", 32'(n), 32'(S));
    tick();
    chk("pres_acc_before_rst", 32'(accept_cnt), 32'(exp_acc));
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_op", 32'(op), 32'd0);
    chk("midrst_acc", 32'(accept_cnt), 32'd0);
    chk("midrst_err", 32'(err_multi), 32'd0);
    rst = 1'b0;
    req = 16'd0;
    tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
